// File: rtl/uart_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : uart_receiver                                              |
// | Description : 8N1 UART receiver (1 start, 8 data LSB first, 1 stop).     |
// |               Synchronises the asynchronous rx_pin, oversamples it with  |
// |               an internal tick generator and delivers each byte on a     |
// |               valid/ready handshake with framing and overrun flags.      |
// | Revision    : 1.0  - initial release                                     |
// +--------------------------------------------------------------------------+
//
// Parameters
//   CLOCK_FREQ  system clock frequency in Hz
//   BAUD_RATE   line bit rate
//   OVERSAMPLE  ticks per bit period (even, >= 8)
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous active-high reset
//   rx_pin       in   1  asynchronous serial line, idles high
//   rx_data      out  8  received byte, stable while rx_valid=1
//   rx_valid     out  1  byte available, held until accepted
//   rx_ready     in   1  consumer accepts on rx_valid & rx_ready
//   frame_err    out  1  one-cycle pulse: stop bit sampled low
//   overrun_err  out  1  one-cycle pulse: byte completed while the
//                        previous one was still unaccepted
//------------------------------------------------------------------------------
module uart_receiver #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun_err
);

   //---------------------------------------------------------------------------
   // Constants
   //---------------------------------------------------------------------------
   // Clock cycles per oversample tick (integer floor).
   localparam int c_DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
   localparam int c_TW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam int c_SW      = $clog2(OVERSAMPLE);

   localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);
   localparam logic [c_SW-1:0] c_S_HALF    = c_SW'(OVERSAMPLE / 2 - 1);
   localparam logic [c_SW-1:0] c_S_LAST    = c_SW'(OVERSAMPLE - 1);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_START = 2'd1;
   localparam logic [1:0] c_ST_DATA  = 2'd2;
   localparam logic [1:0] c_ST_STOP  = 2'd3;

   //---------------------------------------------------------------------------
   // Declarations
   //---------------------------------------------------------------------------
   logic            r_sync1;
   logic            r_rx_s;
   logic            r_rx_prev;

   logic [c_TW-1:0] r_tick_cnt;
   logic [c_SW-1:0] r_s_cnt;
   logic [2:0]      r_b_cnt;
   logic [7:0]      r_shift;

   logic [1:0]      r_state;
   logic [1:0]      w_state_next;

   logic            w_tick;
   logic            w_start_edge;
   logic            w_s_half;
   logic            w_s_last;

   logic            w_arm;        // start edge accepted in IDLE
   logic            w_start_ok;   // start bit confirmed low at its midpoint
   logic            w_shift;      // sample a data bit
   logic            w_complete;   // stop bit good, byte ready to deliver
   logic            w_frame_bad;  // stop bit sampled low

   //---------------------------------------------------------------------------
   // Input synchroniser and edge detection
   //---------------------------------------------------------------------------
   // All three flops reset high so that reset itself never looks like a
   // falling edge on an idle line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= rx_pin;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;
      end
   end

   // Requiring rx_prev=1 means a line stuck low never re-arms the receiver.
   assign w_start_edge = r_rx_prev & ~r_rx_s;

   //---------------------------------------------------------------------------
   // Oversample tick generator
   //---------------------------------------------------------------------------
   assign w_tick = (r_tick_cnt == c_TICK_LAST);

   // Restarting the divider on the start edge aligns every later tick to the
   // edge, so tick k lands exactly k*DIV cycles after edge detection.
   always_ff @(posedge clk) begin
      if (rst || w_arm || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   assign w_s_half = (r_s_cnt == c_S_HALF);
   assign w_s_last = (r_s_cnt == c_S_LAST);

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_start_edge) begin
               w_state_next = c_ST_START;
            end
         end
         c_ST_START: begin
            // A start bit that is high again at its midpoint is a glitch.
            if (w_tick && w_s_half) begin
               w_state_next = r_rx_s ? c_ST_IDLE : c_ST_DATA;
            end
         end
         c_ST_DATA: begin
            if (w_tick && w_s_last && (r_b_cnt == 3'd7)) begin
               w_state_next = c_ST_STOP;
            end
         end
         c_ST_STOP: begin
            // Leaving at the stop-bit midpoint leaves half a bit of margin
            // to catch a start bit that follows with no idle gap.
            if (w_tick && w_s_last) begin
               w_state_next = c_ST_IDLE;
            end
         end
         default: begin
            w_state_next = c_ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: output (control strobe) logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_arm       = 1'b0;
      w_start_ok  = 1'b0;
      w_shift     = 1'b0;
      w_complete  = 1'b0;
      w_frame_bad = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            w_arm = w_start_edge;
         end
         c_ST_START: begin
            w_start_ok = w_tick & w_s_half & ~r_rx_s;
         end
         c_ST_DATA: begin
            w_shift = w_tick & w_s_last;
         end
         c_ST_STOP: begin
            w_complete  = w_tick & w_s_last &  r_rx_s;
            w_frame_bad = w_tick & w_s_last & ~r_rx_s;
         end
         default: begin
            w_arm = 1'b0;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Sample counter, bit counter and shift register
   //---------------------------------------------------------------------------
   // s_cnt is cleared at the start edge and again at the start-bit midpoint,
   // so every data/stop sample falls a whole bit period after the previous
   // midpoint.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s_cnt <= '0;
      end else if (w_arm || w_start_ok || w_shift) begin
         r_s_cnt <= '0;
      end else if (w_tick && (r_state != c_ST_IDLE)) begin
         r_s_cnt <= r_s_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_b_cnt <= 3'd0;
      end else if (w_start_ok) begin
         r_b_cnt <= 3'd0;
      end else if (w_shift) begin
         r_b_cnt <= r_b_cnt + 3'd1;
      end
   end

   // LSB arrives first, so shifting right with new bits entering at the MSB
   // leaves bit 0 in position 0 after eight shifts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= 8'h00;
      end else if (w_shift) begin
         r_shift <= {r_rx_s, r_shift[7:1]};
      end
   end

   //---------------------------------------------------------------------------
   // Output register and handshake
   //---------------------------------------------------------------------------
   // A completion that coincides with a handshake replaces the accepted byte
   // directly; a completion while the old byte is still pending drops the new
   // byte and reports an overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_err   <= w_frame_bad;
         overrun_err <= w_complete & rx_valid & ~rx_ready;
         if (w_complete && (!rx_valid || rx_ready)) begin
            rx_data  <= r_shift;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_receiver                                           |
// | Description : Self-checking bench for uart_receiver. Table of single     |
// |               frames plus hand-written multi-frame sequences.            |
// | Revision    : 1.0  - initial release                                     |
// +--------------------------------------------------------------------------+
module tb_uart_receiver;

   localparam int CLK_F   = 1_600_000;
   localparam int BAUD    = 10_000;
   localparam int OS      = 16;
   localparam int BIT_CYC = 160;              // DIV=10, 16 ticks per bit
   localparam int LAT     = 2 + (8 + 144) * 10; // pin fall -> rx_valid rise

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_pin;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun_err;

   uart_receiver #(
      .CLOCK_FREQ (CLK_F),
      .BAUD_RATE  (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_pin      (rx_pin),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_err   (frame_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   //---------------------------------------------------------------------------
   // Output monitor (samples on the falling edge)
   //---------------------------------------------------------------------------
   int         n_rise    = 0;
   int         n_vcyc    = 0;
   int         n_ferr    = 0;
   int         n_oerr    = 0;
   int         last_rise = 0;
   bit         prev_valid = 1'b0;
   logic [7:0] hs_q[$];

   always @(negedge clk) begin
      if (rx_valid && !prev_valid) begin
         n_rise++;
         last_rise = cyc;
      end
      if (rx_valid) n_vcyc++;
      if (rx_valid && rx_ready) hs_q.push_back(rx_data);
      if (frame_err) n_ferr++;
      if (overrun_err) n_oerr++;
      prev_valid = rx_valid;
   end

   //---------------------------------------------------------------------------
   // Checking helpers
   //---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;
   int last_fall = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_tol(input string name, input int act, input int exp, input int tol);
      n_checks++;
      if ((act < exp - tol) || (act > exp + tol)) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d+/-%0d", name, act, exp, tol);
      end
   endtask

   function automatic int hs_at(input int idx);
      if (hs_q.size() > idx) return int'(hs_q[idx]);
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      rx_pin = v;
      repeat (n) step();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      step();
      last_fall = cyc;
      for (int i = 0; i < 10; i++) hold(f[i], BIT_CYC);
   endtask

   //---------------------------------------------------------------------------
   // Vector table: one frame each, rx_ready held high
   //---------------------------------------------------------------------------
   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_hs;
      int         exp_vcyc;
      int         exp_ferr;
      int         exp_oerr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int s_hs, s_v, s_f, s_o, s_r;
      logic [9:0] f;

      vecs[0] = '{8'hA5, 1'b1, 1, 1, 0, 0, 8'hA5};
      vecs[1] = '{8'h00, 1'b1, 1, 1, 0, 0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1, 1, 0, 0, 8'hFF};
      vecs[3] = '{8'h55, 1'b1, 1, 1, 0, 0, 8'h55};
      vecs[4] = '{8'h7E, 1'b0, 0, 0, 1, 0, 8'h00};
      vecs[5] = '{8'h12, 1'b1, 1, 1, 0, 0, 8'h12};

      rst = 1'b1; rx_pin = 1'b1; rx_ready = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check("reset_rx_data", int'(rx_data), 0);
      check("reset_rx_valid", int'(rx_valid), 0);
      check("reset_frame_err", int'(frame_err), 0);
      check("reset_overrun_err", int'(overrun_err), 0);
      repeat (20) step();

      // Table-driven single frames.
      for (int i = 0; i < 6; i++) begin
         s_hs = hs_q.size(); s_v = n_vcyc; s_f = n_ferr; s_o = n_oerr;
         send_frame(vecs[i].data, vecs[i].stop);
         hold(1'b1, 200);
         @(negedge clk);
         check($sformatf("vec%0d_handshakes", i), hs_q.size() - s_hs, vecs[i].exp_hs);
         check($sformatf("vec%0d_valid_cycles", i), n_vcyc - s_v, vecs[i].exp_vcyc);
         check($sformatf("vec%0d_frame_err", i), n_ferr - s_f, vecs[i].exp_ferr);
         check($sformatf("vec%0d_overrun_err", i), n_oerr - s_o, vecs[i].exp_oerr);
         if (vecs[i].exp_hs == 1) begin
            check($sformatf("vec%0d_data", i), hs_at(s_hs), int'(vecs[i].exp_data));
            check_tol($sformatf("vec%0d_latency", i), last_rise - last_fall, LAT, 10);
         end
      end

      // Back-to-back frames with no idle gap.
      s_hs = hs_q.size(); s_v = n_vcyc; s_f = n_ferr;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      hold(1'b1, 200);
      @(negedge clk);
      check("b2b_handshakes", hs_q.size() - s_hs, 3);
      check("b2b_data0", hs_at(s_hs), 8'h00);
      check("b2b_data1", hs_at(s_hs + 1), 8'hFF);
      check("b2b_data2", hs_at(s_hs + 2), 8'h55);
      check("b2b_valid_cycles", n_vcyc - s_v, 3);
      check("b2b_frame_err", n_ferr - s_f, 0);

      // Overrun: two frames with rx_ready low.
      step();
      rx_ready = 1'b0;
      s_r = n_rise; s_o = n_oerr; s_f = n_ferr;
      send_frame(8'h3C, 1'b1);
      hold(1'b1, 200);
      @(negedge clk);
      check("ovr_first_overrun", n_oerr - s_o, 0);
      send_frame(8'h81, 1'b1);
      hold(1'b1, 200);
      @(negedge clk);
      check("ovr_rx_valid", int'(rx_valid), 1);
      check("ovr_rx_data", int'(rx_data), 8'h3C);
      check("ovr_overrun_pulses", n_oerr - s_o, 1);
      check("ovr_valid_rises", n_rise - s_r, 1);
      check("ovr_frame_err", n_ferr - s_f, 0);
      step();
      rx_ready = 1'b1;
      step();
      @(negedge clk);
      check("ovr_valid_cleared", int'(rx_valid), 0);

      // 40-cycle glitch, then a real frame.
      s_hs = hs_q.size(); s_f = n_ferr; s_r = n_rise;
      step();
      hold(1'b0, 40);
      hold(1'b1, 300);
      @(negedge clk);
      check("glitch_valid_rises", n_rise - s_r, 0);
      check("glitch_frame_err", n_ferr - s_f, 0);
      send_frame(8'h96, 1'b1);
      hold(1'b1, 200);
      @(negedge clk);
      check("glitch_next_handshakes", hs_q.size() - s_hs, 1);
      check("glitch_next_data", hs_at(s_hs), 8'h96);

      // Bad stop bit followed by a long low line.
      s_hs = hs_q.size(); s_f = n_ferr; s_r = n_rise;
      send_frame(8'h7E, 1'b0);
      hold(1'b0, 2000);
      @(negedge clk);
      check("ferr_pulses", n_ferr - s_f, 1);
      check("ferr_valid_rises", n_rise - s_r, 0);
      check("ferr_rx_valid", int'(rx_valid), 0);
      step();
      hold(1'b1, 200);
      send_frame(8'h12, 1'b1);
      hold(1'b1, 200);
      @(negedge clk);
      check("ferr_next_handshakes", hs_q.size() - s_hs, 1);
      check("ferr_next_data", hs_at(s_hs), 8'h12);
      check("ferr_total_pulses", n_ferr - s_f, 1);

      // Reset during data bit 4 while an unaccepted byte is pending.
      step();
      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1);
      hold(1'b1, 200);
      @(negedge clk);
      check("rstmid_pending_valid", int'(rx_valid), 1);
      check("rstmid_pending_data", int'(rx_data), 8'h5A);
      step();
      f = {1'b1, 8'hF0, 1'b0};
      for (int i = 0; i < 5; i++) hold(f[i], BIT_CYC);
      hold(f[5], 80);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_rx_data", int'(rx_data), 0);
      check("rstmid_rx_valid", int'(rx_valid), 0);
      check("rstmid_frame_err", int'(frame_err), 0);
      check("rstmid_overrun_err", int'(overrun_err), 0);
      s_r = n_rise; s_f = n_ferr;
      step();
      hold(f[5], 78);
      for (int i = 6; i < 10; i++) hold(f[i], BIT_CYC);
      hold(1'b1, 200);
      @(negedge clk);
      check("rstmid_tail_ignored", n_rise - s_r, 0);
      check("rstmid_tail_frame_err", n_ferr - s_f, 0);
      step();
      rx_ready = 1'b1;
      s_hs = hs_q.size();
      send_frame(8'hC3, 1'b1);
      hold(1'b1, 200);
      @(negedge clk);
      check("rstmid_next_handshakes", hs_q.size() - s_hs, 1);
      check("rstmid_next_data", hs_at(s_hs), 8'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for 8N1 frames (1 start, 8 data LSB first, 1 stop, no parity). It is the receive-side counterpart of the team's UART transmitter and shares its CLOCK_FREQ/BAUD_RATE parameterisation. The block synchronises the asynchronous rx_pin and oversamples it with an internal tick generator. Each byte is presented on a valid/ready handshake, with framing and overrun errors flagged.

## Interface
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line bit rate
- OVERSAMPLE, 16, ticks per bit period; must be even and ≥ 8
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_pin  input  1  asynchronous serial line; idles high
- rx_data  output  8  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  one-cycle pulse: a byte completed while the previous one was unaccepted

## Operation
- Synchroniser: two flops on rx_pin, both reset to 1. rx_s is the second flop. rx_prev holds the previous rx_s and also resets to 1.
- Tick generator: DIV = CLOCK_FREQ / (BAUD_RATE*OVERSAMPLE), integer floor. Counter runs 0..DIV-1 and pulses tick when at DIV-1. The counter is forced to 0 in the cycle a start edge is detected.
- Sample counter s_cnt counts ticks within a bit. Bit counter b_cnt is 3 bits. Shift register is 8 bits and shifts right, with each new bit entering at MSB.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: a start edge is rx_prev=1 & rx_s=0. On a start edge, clear s_cnt and the tick counter, then go to START. A line held low never re-arms; a high level must be seen first.
  - START: on the tick that makes s_cnt reach OVERSAMPLE/2-1, sample rx_s.
    - If rx_s=0, clear s_cnt and b_cnt, then go to DATA.
    - If rx_s=1, treat it as a glitch: go to IDLE with no output.
  - DATA: on the tick where s_cnt reaches OVERSAMPLE-1, shift rx_s in, clear s_cnt and increment b_cnt. After the 8th bit (b_cnt was 7), go to STOP.
  - STOP: on the tick where s_cnt reaches OVERSAMPLE-1, sample rx_s, then go to IDLE.
    - rx_s=1: completion event; the byte is delivered per the output rules below.
    - rx_s=0: pulse frame_err; the byte is discarded and rx_valid/rx_data are unchanged.
- Output register rules, evaluated each cycle:
  - Handshake (rx_valid & rx_ready) with no completion: rx_valid goes to 0 next cycle.
  - Completion with rx_valid=0, or completion in the same cycle as a handshake: load rx_data and set rx_valid=1. No overrun.
  - Completion with rx_valid=1 and rx_ready=0: the new byte is dropped, the old byte is retained and overrun_err pulses.
- Reset mid-frame: the FSM returns to IDLE and the partial byte is lost. Every output takes its reset value next cycle.

## Timing
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun_err=0. The FSM is in IDLE.
- Input latency: rx_pin to rx_s is 2 cycles.
- Edge detection to samples, in ticks:
  - start-bit check: OVERSAMPLE/2
  - data bit n (n=0..7): OVERSAMPLE/2 + OVERSAMPLE*(n+1)
  - stop bit: OVERSAMPLE/2 + 9*OVERSAMPLE
- Tick to cycles: tick k occurs k*DIV cycles after the edge-detect cycle.
- rx_valid, frame_err and overrun_err update in the cycle after the stop-sample tick.
- The FSM is back in IDLE at the midpoint of the stop bit. A start bit immediately following the stop bit is therefore caught.
- Baud mismatch tolerance is ±4% cumulative over the frame. This is a design target, not a checked function.

## Test plan
All scenarios use CLOCK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, giving DIV=10 and 160 cycles/bit.
- Drive 0xA5 with rx_ready=1 -> rx_data=0xA5 and rx_valid=1 for exactly 1 cycle. The rise comes 2+(8+144)*10 cycles after the rx_pin fall, within ±10 cycles. No error pulses.
- Drive back-to-back 0x00, 0xFF, 0x55 with no idle gap and rx_ready=1 -> three valid pulses with the correct data in order.
- Drive 0x3C and 0x81 with rx_ready=0 throughout -> rx_valid stays 1 and rx_data stays 0x3C. overrun_err pulses once at the end of the second frame. Asserting rx_ready afterwards clears rx_valid next cycle.
- Drive a low pulse of 40 cycles, then idle -> no rx_valid and no frame_err; the FSM returns to IDLE.
- Drive 0x7E with the stop bit low, then hold the line low for 2000 cycles -> frame_err pulses once, with no rx_valid and no new frame. After the line returns high, a following 0x12 is received correctly.
- Assert rst for 1 cycle during data bit 4 of a frame -> outputs are at reset values. The rest of that frame is ignored until a fresh high-to-low edge, after which the next full frame 0xC3 is received correctly.
